tdm_mux_8to1: RTL

//   Sequential 8:1 time-division multiplexer; transmit-side counterpart of demux_1to8.
//   On start, captures an 8-bit channel word and sends it one channel per enabled cycle
//   on a single line, with the matching 3-bit sel, so a downstream demux_1to8 fed out/sel

---
 rtl/tdm_pkg.sv | 13 +
 rtl/mux_8to1.sv | 10 +
 rtl/tdm_mux_8to1.sv | 107 ++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM transmit/receive pair: channel count, select width,
// idle line level and the frame FSM state type.
package tdm_pkg;
  localparam int         NUM_CH     = 8;
  localparam int         SEL_W      = $clog2(NUM_CH);
  localparam logic       IDLE_LEVEL = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tdm_state_t;
endpackage

// File: rtl/mux_8to1.sv
// Pure combinational channel select: bit_o = word_i[sel_i].
module mux_8to1
  import tdm_pkg::*;
(
  input  logic [NUM_CH-1:0] word_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic              bit_o
);
  assign bit_o = word_i[sel_i];
endmodule

// File: rtl/tdm_mux_8to1.sv
// Sequential 8:1 TDM transmitter: captures a channel word on start and serialises it
// one channel per enabled cycle, with a matching select, for a downstream demux_1to8.
module tdm_mux_8to1
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_CH-1:0] in,
  input  logic              en,
  output logic              out,
  output logic [SEL_W-1:0]  sel,
  output logic              valid,
  output logic              busy,
  output logic              done
);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

  tdm_state_t        state_q, state_d;
  logic [NUM_CH-1:0] word_q, word_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              out_q, out_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mux_bit;

  // The mux looks at next-state word/sel so out is registered in step with sel/valid.
  mux_8to1 u_mux (
    .word_i (word_d),
    .sel_i  (sel_d),
    .bit_o  (mux_bit)
  );

  // Interface: start is a request sampled only in IDLE/DONE (accepted the same edge, no
  // ready); en is a per-cycle advance qualifier in SEND; valid marks out/sel as a frame bit.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SEND;
          word_d  = in;
          sel_d   = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          sel_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      SEND: begin
        if (en) begin
          if (sel_q == LAST_SEL) begin
            state_d = DONE;
            sel_d   = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
    out_d = valid_d ? mux_bit : IDLE_LEVEL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      sel_q   <= '0;
      out_q   <= IDLE_LEVEL;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out   = out_q;
  assign sel   = sel_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
endmodule
